// File: rtl/final_soc_otg_hpi_sequencer.sv
// CY7C67200 HPI bus-cycle sequencer: turns one accepted request into a
// timed setup/strobe/hold cycle on the OTG pins and returns a response pulse.
module final_soc_otg_hpi_sequencer #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int CNT_W      = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_addr_i,
    input  logic [15:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic [1:0]  otg_addr_o,
    output logic        otg_cs_n_o,
    output logic        otg_rd_n_o,
    output logic        otg_wr_n_o,
    input  logic [15:0] otg_data_in_i,
    output logic [15:0] otg_data_out_o,
    output logic        otg_data_oe_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Counters are loaded with (cycles - 1) and the phase ends when they reach zero.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [1:0]         addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               cs_n_q, cs_n_d;
    logic               rd_n_q, rd_n_d;
    logic               wr_n_q, wr_n_d;
    logic               oe_q, oe_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               ready_q, ready_d;
    logic               accept_s;

    // Next-state, latched request fields and pin values derived from the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        accept_s    = req_valid_i & ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    if (SETUP_CYC != 0) begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = ST_STROBE;
                        cnt_d   = STROBE_LD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (cnt_q == CNT_ZERO) begin
                    // Final strobe clock: rd_n is still low on the pins here.
                    if (!write_q) begin
                        rdata_d = otg_data_in_i;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    if (HOLD_CYC != 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        cs_n_d  = (state_d == ST_IDLE);
        rd_n_d  = !((state_d == ST_STROBE) && !write_d);
        wr_n_d  = !((state_d == ST_STROBE) && write_d);
        oe_d    = (state_d != ST_IDLE) && write_d;
        ready_d = (state_d == ST_IDLE);
    end

    // State, latched request and registered pin drivers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            write_q     <= 1'b0;
            addr_q      <= 2'd0;
            wdata_q     <= 16'h0000;
            rdata_q     <= 16'h0000;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rdata_q;
    assign otg_addr_o     = addr_q;
    assign otg_cs_n_o     = cs_n_q;
    assign otg_rd_n_o     = rd_n_q;
    assign otg_wr_n_o     = wr_n_q;
    assign otg_data_out_o = wdata_q;
    assign otg_data_oe_o  = oe_q;

endmodule

// File: tb/tb_final_soc_otg_hpi_sequencer.sv
// Directed bench for the HPI sequencer: default timing instance plus a
// minimum-timing instance (no setup/hold, single strobe clock).
module tb_final_soc_otg_hpi_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        a_valid, a_ready, a_write, a_rsp_valid, a_cs_n, a_rd_n, a_wr_n, a_oe;
    logic [1:0]  a_addr, a_otg_addr;
    logic [15:0] a_wdata, a_rdata, a_din, a_dout;

    logic        b_valid, b_ready, b_write, b_rsp_valid, b_cs_n, b_rd_n, b_wr_n, b_oe;
    logic [1:0]  b_addr, b_otg_addr;
    logic [15:0] b_wdata, b_rdata, b_din, b_dout;

    always #5 clk = ~clk;

    final_soc_otg_hpi_sequencer dut_a (
        .clk_i(clk), .reset_i(rst),
        .req_valid_i(a_valid), .req_ready_o(a_ready), .req_write_i(a_write),
        .req_addr_i(a_addr), .req_wdata_i(a_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rdata),
        .otg_addr_o(a_otg_addr), .otg_cs_n_o(a_cs_n), .otg_rd_n_o(a_rd_n),
        .otg_wr_n_o(a_wr_n), .otg_data_in_i(a_din), .otg_data_out_o(a_dout),
        .otg_data_oe_o(a_oe)
    );

    final_soc_otg_hpi_sequencer #(
        .SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0), .CNT_W(4)
    ) dut_b (
        .clk_i(clk), .reset_i(rst),
        .req_valid_i(b_valid), .req_ready_o(b_ready), .req_write_i(b_write),
        .req_addr_i(b_addr), .req_wdata_i(b_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rdata),
        .otg_addr_o(b_otg_addr), .otg_cs_n_o(b_cs_n), .otg_rd_n_o(b_rd_n),
        .otg_wr_n_o(b_wr_n), .otg_data_in_i(b_din), .otg_data_out_o(b_dout),
        .otg_data_oe_o(b_oe)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, let the next edge accept it; returns just after that edge.
    task automatic start_req(input logic wr, input logic [1:0] a, input logic [15:0] wd, input bit hold);
        a_write = wr;
        a_addr  = a;
        a_wdata = wd;
        a_valid = 1'b1;
        check_eq("ready_before_accept", 32'(a_ready), 32'd1);
        tick();
        if (!hold) a_valid = 1'b0;
    endtask

    // Check the 2+4+2 window after an accept edge (e = edges since accept);
    // returns in the rsp_valid cycle without advancing past it.
    task automatic txn_window(input logic wr, input logic [1:0] a, input logic [15:0] wd,
                              input logic [15:0] rd_drive, input logic [15:0] rd_exp,
                              input bit scramble);
        logic strobe;
        logic [4:0] exp_pins;
        for (int e = 0; e <= 8; e++) begin
            strobe   = (e >= 2) && (e <= 5);
            exp_pins = {(e > 7), !(strobe && !wr), !(strobe && wr), (e <= 7) && wr, (e == 8)};
            check_eq("pins_cs_rd_wr_oe_rsp", 32'({a_cs_n, a_rd_n, a_wr_n, a_oe, a_rsp_valid}), 32'(exp_pins));
            check_eq("ready", 32'(a_ready), 32'(e == 8));
            check_eq("rd_wr_exclusive", 32'(a_rd_n | a_wr_n), 32'd1);
            if (e <= 7) begin
                check_eq("otg_addr", 32'(a_otg_addr), 32'(a));
                if (wr) check_eq("otg_data_out", 32'(a_dout), 32'(wd));
            end
            if (e == 8) check_eq("rsp_rdata", 32'(a_rdata), 32'(rd_exp));
            a_din = strobe ? rd_drive : 16'h5A5A;
            if (scramble) begin
                a_addr  = 2'(e) ^ 2'b11;
                a_wdata = 16'(e) ^ 16'hFFFF;
                a_write = ~a_write;
            end
            if (e < 8) tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_write = 1'b0; a_addr = 2'd0; a_wdata = 16'h0000; a_din = 16'h0000;
        b_valid = 1'b0; b_write = 1'b0; b_addr = 2'd0; b_wdata = 16'h0000; b_din = 16'h0000;
        tick();
        tick();
        check_eq("rst_pins", 32'({a_cs_n, a_rd_n, a_wr_n, a_oe, a_rsp_valid}), 32'(5'b11100));
        check_eq("rst_ready", 32'(a_ready), 32'd1);
        check_eq("rst_addr_dout_rdata", {14'd0, a_otg_addr, a_dout}, 32'd0);
        check_eq("rst_rdata", 32'(a_rdata), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("idle_pins", 32'({a_cs_n, a_rd_n, a_wr_n, a_oe, a_rsp_valid}), 32'(5'b11100));

        // Write with default timing
        start_req(1'b1, 2'd2, 16'h1234, 1'b0);
        txn_window(1'b1, 2'd2, 16'h1234, 16'hBEEF, 16'h0000, 1'b0);
        tick();
        // Read returning BEEF
        start_req(1'b0, 2'd0, 16'h0000, 1'b0);
        txn_window(1'b0, 2'd0, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0);
        tick();
        // Write with request inputs scrambled every clock; rdata must stay BEEF
        start_req(1'b1, 2'd1, 16'hA5A5, 1'b0);
        txn_window(1'b1, 2'd1, 16'hA5A5, 16'h1111, 16'hBEEF, 1'b1);
        tick();

        // Back-to-back write then read with req_valid held
        start_req(1'b1, 2'd3, 16'h0F0F, 1'b1);
        a_write = 1'b0; a_addr = 2'd2; a_wdata = 16'hFFFF;
        txn_window(1'b1, 2'd3, 16'h0F0F, 16'h2222, 16'hBEEF, 1'b0);
        check_eq("b2b_cs_gap_high", 32'(a_cs_n), 32'd1);
        tick();
        a_valid = 1'b0;
        txn_window(1'b0, 2'd2, 16'hFFFF, 16'hC0DE, 16'hC0DE, 1'b0);
        tick();
        check_eq("b2b_idle_after", 32'({a_cs_n, a_ready, a_rsp_valid}), 32'(3'b110));

        // Minimum timing instance: read then write
        b_valid = 1'b1; b_write = 1'b0; b_addr = 2'd1;
        check_eq("min_ready", 32'(b_ready), 32'd1);
        tick();
        b_valid = 1'b0;
        check_eq("min_rd_strobe", 32'({b_cs_n, b_rd_n, b_wr_n, b_oe, b_rsp_valid}), 32'(5'b00100));
        check_eq("min_rd_addr", 32'(b_otg_addr), 32'd1);
        b_din = 16'h1357;
        tick();
        b_din = 16'h0000;
        check_eq("min_rd_rsp", 32'({b_cs_n, b_rd_n, b_wr_n, b_oe, b_rsp_valid}), 32'(5'b11101));
        check_eq("min_rd_rdata", 32'(b_rdata), 32'h1357);
        b_valid = 1'b1; b_write = 1'b1; b_addr = 2'd3; b_wdata = 16'h2468;
        tick();
        b_valid = 1'b0;
        check_eq("min_wr_strobe", 32'({b_cs_n, b_rd_n, b_wr_n, b_oe, b_rsp_valid}), 32'(5'b01010));
        check_eq("min_wr_dout", 32'(b_dout), 32'h2468);
        tick();
        check_eq("min_wr_rsp", 32'({b_cs_n, b_rd_n, b_wr_n, b_oe, b_rsp_valid}), 32'(5'b11101));
        check_eq("min_wr_rdata_kept", 32'(b_rdata), 32'h1357);
        tick();
        check_eq("min_rsp_one_pulse", 32'(b_rsp_valid), 32'd0);

        // Reset on the 2nd strobe clock of a write
        start_req(1'b1, 2'd1, 16'h7777, 1'b0);
        tick();
        tick();
        tick();
        check_eq("abort_pre_wr_n", 32'(a_wr_n), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("abort_pins", 32'({a_cs_n, a_rd_n, a_wr_n, a_oe, a_rsp_valid}), 32'(5'b11100));
        check_eq("abort_addr_dout", {14'd0, a_otg_addr, a_dout}, 32'd0);
        check_eq("abort_ready", 32'(a_ready), 32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("abort_no_rsp", 32'({a_rsp_valid, a_ready, a_cs_n}), 32'(3'b011));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
